endpoint_rx_mq: RTL and testbench

- Next-generation endpoint receive buffer with NUM_CH independent receive queues, selected per word by the RX FSM, replacing the single fixed RX FIFO.
- Each queue tracks packet boundaries, word and packet counts, and a sticky overrun flag.
- Exposes a memory-mapped peripheral register window and a level interrupt.
- Sits between rx_fsm (write side) and the endpoint bus decode (read side).

---
 rtl/endpoint_rx_mq_pkg.sv | 26 ++
 rtl/endpoint_rx_mq_queue.sv | 99 +++++++++
 rtl/endpoint_rx_mq.sv | 161 ++++++++++++++++
 tb/tb_endpoint_rx_mq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/endpoint_rx_mq_pkg.sv
// Shared constants and types for the multi-queue endpoint receive buffer.
// Register offsets are byte offsets inside a channel's 0x40-byte window.
package endpoint_rx_mq_pkg;

    localparam int unsigned CH_STRIDE     = 32'h040;
    localparam int unsigned DATA_OFF      = 32'h0;
    localparam int unsigned WCNT_OFF      = 32'h4;
    localparam int unsigned PCNT_OFF      = 32'h8;
    localparam int unsigned STAT_OFF      = 32'hC;
    localparam int unsigned IRQ_PEND_ADDR = 32'h800;
    localparam int unsigned IRQ_MASK_ADDR = 32'h804;

    localparam logic [31:0] BAD_RDATA = 32'hBAD1BAD1;

    // Bit order matches the STATUS register: bit0 empty, bit1 full, bit2 overrun.
    typedef struct packed {
        logic overrun;
        logic full;
        logic empty;
    } rx_status_t;

    function automatic logic [31:0] status_word(input rx_status_t s);
        return {29'b0, s};
    endfunction

endpackage

// File: rtl/endpoint_rx_mq_queue.sv
// One receive queue: circular {last, data} buffer with word/packet counts
// and a sticky overrun flag. Head word is readable combinationally.
module rx_mq_queue
    import endpoint_rx_mq_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push_en,
    input  logic [31:0]      push_data,
    input  logic             push_last,
    input  logic             pop_en,
    input  logic             ovr_clr,
    output logic [31:0]      head_data,
    output rx_status_t       status,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] pkt_cnt
);

    logic [32:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             ovr_q, ovr_d;
    logic             empty, full, pop_ok, push_ok, head_last;

    assign empty     = (wcnt_q == '0);
    assign full      = (wcnt_q == CNT_W'(DEPTH));
    assign pop_ok    = pop_en && !empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push_ok   = push_en && (!full || pop_ok);
    assign head_last = mem_q[head_q][32];
    assign head_data = mem_q[head_q][31:0];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        wcnt_d = wcnt_q;
        pcnt_d = pcnt_q;
        ovr_d  = ovr_q;
        if (pop_ok) begin
            head_d = head_q + 1'b1;
        end
        if (push_ok) begin
            tail_d = tail_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            wcnt_d = wcnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            wcnt_d = wcnt_q - 1'b1;
        end
        if (push_ok && push_last) begin
            pcnt_d = pcnt_d + 1'b1;
        end
        if (pop_ok && head_last) begin
            pcnt_d = pcnt_d - 1'b1;
        end
        // Clear first so a same-cycle overflow leaves the flag set.
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (push_en && !push_ok) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q <= '0;
            tail_q <= '0;
            wcnt_q <= '0;
            pcnt_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            wcnt_q <= wcnt_d;
            pcnt_q <= pcnt_d;
            ovr_q  <= ovr_d;
        end
    end

    assign status.empty   = empty;
    assign status.full    = full;
    assign status.overrun = ovr_q;
    assign word_cnt       = wcnt_q;
    assign pkt_cnt        = pcnt_q;

endmodule

// File: rtl/endpoint_rx_mq.sv
// Endpoint receive buffer with NUM_CH queues, register window and level irq.
// Define RX_MQ_STALL_EN to stall (instead of error) DATA reads on an empty queue.
module endpoint_rx_mq
    import endpoint_rx_mq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 12,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  rx_wen,
    input  logic [CH_W-1:0]       rx_ch,
    input  logic [31:0]           rx_wdata,
    input  logic                  rx_last,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic                  bus_ren,
    input  logic                  bus_wen,
    input  logic [31:0]           bus_wdata,
    output logic [31:0]           bus_rdata,
    output logic                  bus_error,
    output logic                  bus_request_stall,
    output logic                  irq
);

    localparam int CHF_W = ADDR_WIDTH - 6;

    logic [31:0]       head_data [NUM_CH];
    rx_status_t        status    [NUM_CH];
    logic [CNT_W-1:0]  wcnt      [NUM_CH];
    logic [CNT_W-1:0]  pcnt      [NUM_CH];
    logic [NUM_CH-1:0] push_sel, pop_sel, clr_sel, pend, ch_onehot;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              irq_q, irq_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign push_sel[gi] = rx_wen && (rx_ch == CH_W'(gi));
            assign pend[gi]     = (pcnt[gi] != '0);

            rx_mq_queue #(.DEPTH(DEPTH)) u_queue (
                .clk       (clk),
                .n_rst     (n_rst),
                .push_en   (push_sel[gi]),
                .push_data (rx_wdata),
                .push_last (rx_last),
                .pop_en    (pop_sel[gi]),
                .ovr_clr   (clr_sel[gi]),
                .head_data (head_data[gi]),
                .status    (status[gi]),
                .word_cnt  (wcnt[gi]),
                .pkt_cnt   (pcnt[gi])
            );
        end
    endgenerate

    logic [CHF_W-1:0] ch_field;
    logic [5:0]       off;
    logic             ch_reg;
    logic [31:0]      sel_head;
    rx_status_t       sel_stat;
    logic [CNT_W-1:0] sel_wcnt, sel_pcnt;

    assign ch_field = bus_addr[ADDR_WIDTH-1:6];
    assign off      = bus_addr[5:0];
    // Global registers sit far above the last possible channel window.
    assign ch_reg   = (ch_field < CHF_W'(NUM_CH)) && (off[5:4] == 2'b00) && (off[1:0] == 2'b00);

    always_comb begin
        ch_onehot = '0;
        sel_head  = '0;
        sel_stat  = '0;
        sel_wcnt  = '0;
        sel_pcnt  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_field == CHF_W'(c)) begin
                ch_onehot[c] = 1'b1;
                sel_head     = head_data[c];
                sel_stat     = status[c];
                sel_wcnt     = wcnt[c];
                sel_pcnt     = pcnt[c];
            end
        end
    end

    logic stall_c;

    always_comb begin
        bus_rdata = BAD_RDATA;
        bus_error = 1'b0;
        stall_c   = 1'b0;
        pop_sel   = '0;
        clr_sel   = '0;
        mask_d    = mask_q;
        if (bus_wen) begin
            bus_error = 1'b1;
            if (bus_addr == ADDR_WIDTH'(IRQ_MASK_ADDR)) begin
                mask_d    = bus_wdata[NUM_CH-1:0];
                bus_error = 1'b0;
            end else if (ch_reg && off == 6'(STAT_OFF)) begin
                clr_sel   = ch_onehot & {NUM_CH{bus_wdata[2]}};
                bus_error = 1'b0;
            end
        end else if (bus_ren) begin
            bus_error = 1'b1;
            if (bus_addr == ADDR_WIDTH'(IRQ_PEND_ADDR)) begin
                bus_rdata = 32'(pend);
                bus_error = 1'b0;
            end else if (bus_addr == ADDR_WIDTH'(IRQ_MASK_ADDR)) begin
                bus_rdata = 32'(mask_q);
                bus_error = 1'b0;
            end else if (ch_reg) begin
                if (off == 6'(DATA_OFF)) begin
                    if (!sel_stat.empty) begin
                        bus_rdata = sel_head;
                        bus_error = 1'b0;
                        pop_sel   = ch_onehot;
                    end else begin
`ifdef RX_MQ_STALL_EN
                        // Combinational hold: retried every cycle until a word lands.
                        stall_c   = 1'b1;
                        bus_error = 1'b0;
`endif
                    end
                end else if (off == 6'(WCNT_OFF)) begin
                    bus_rdata = 32'(sel_wcnt);
                    bus_error = 1'b0;
                end else if (off == 6'(PCNT_OFF)) begin
                    bus_rdata = 32'(sel_pcnt);
                    bus_error = 1'b0;
                end else begin
                    bus_rdata = status_word(sel_stat);
                    bus_error = 1'b0;
                end
            end
        end
    end

    assign bus_request_stall = stall_c;

    assign irq_d = |(pend & mask_q);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;

    logic unused_wdata;
    assign unused_wdata = ^bus_wdata;

endmodule

// File: tb/tb_endpoint_rx_mq.sv
// Scoreboard bench for endpoint_rx_mq: a queue-based reference model predicts
// every cycle's bus response and irq; a negedge monitor compares.
module tb_endpoint_rx_mq;
    import endpoint_rx_mq_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 8;
    localparam int AW     = 12;
    localparam int CH_W   = 2;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            rx_wen = 1'b0;
    logic [CH_W-1:0] rx_ch = '0;
    logic [31:0]     rx_wdata = '0;
    logic            rx_last = 1'b0;
    logic [AW-1:0]   bus_addr = '0;
    logic            bus_ren = 1'b0;
    logic            bus_wen = 1'b0;
    logic [31:0]     bus_wdata = '0;
    logic [31:0]     bus_rdata;
    logic            bus_error, bus_request_stall, irq;

    always #5 clk = ~clk;

    endpoint_rx_mq #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .rx_wen            (rx_wen),
        .rx_ch             (rx_ch),
        .rx_wdata          (rx_wdata),
        .rx_last           (rx_last),
        .bus_addr          (bus_addr),
        .bus_ren           (bus_ren),
        .bus_wen           (bus_wen),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_error         (bus_error),
        .bus_request_stall (bus_request_stall),
        .irq               (irq)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        stall;
        logic        irq;
        logic        strobe;
        int          addr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: each queue is a plain list of {last, data}.
    logic [32:0]       mq [NUM_CH][$];
    bit                m_ovr [NUM_CH];
    bit [NUM_CH-1:0]   m_mask;
    bit                m_irq_next;

    function automatic int m_pkts(input int c);
        int n = 0;
        for (int i = 0; i < mq[c].size(); i++) if (mq[c][i][32]) n++;
        return n;
    endfunction

    function automatic bit [NUM_CH-1:0] m_pend();
        bit [NUM_CH-1:0] p = '0;
        for (int c = 0; c < NUM_CH; c++) p[c] = (m_pkts(c) != 0);
        return p;
    endfunction

    function automatic void chk(input string name, input int addr, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @addr=%03h: got %h, expected %h", name, addr, act, exp);
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            m_ovr[c] = 1'b0;
        end
        m_mask     = '0;
        m_irq_next = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit pw, input int pch, input logic [31:0] pd, input bit pl,
                              input bit ren, input bit wen, input int addr, input logic [31:0] wd);
        exp_t e;
        int   c, off;
        bit   is_ch, do_pop, do_clr;
        c      = addr / 64;
        off    = addr % 64;
        is_ch  = (addr < 'h800) && (c < NUM_CH) && (off == 0 || off == 4 || off == 8 || off == 12);
        do_pop = 1'b0;
        do_clr = 1'b0;
        e.rdata  = BAD_RDATA;
        e.err    = 1'b0;
        e.stall  = 1'b0;
        e.irq    = m_irq_next;
        e.strobe = ren || wen;
        e.addr   = addr;
        if (wen) begin
            e.err = 1'b1;
            if (addr == 'h804) begin
                e.err  = 1'b0;
            end else if (is_ch && off == 12) begin
                e.err  = 1'b0;
                do_clr = wd[2];
            end
        end else if (ren) begin
            e.err = 1'b1;
            if (addr == 'h800) begin
                e.rdata = 32'(m_pend());
                e.err   = 1'b0;
            end else if (addr == 'h804) begin
                e.rdata = 32'(m_mask);
                e.err   = 1'b0;
            end else if (is_ch) begin
                e.err = 1'b0;
                case (off)
                    0: begin
                        if (mq[c].size() > 0) begin
                            e.rdata = mq[c][0][31:0];
                            do_pop  = 1'b1;
                        end else begin
`ifdef RX_MQ_STALL_EN
                            e.stall = 1'b1;
`else
                            e.err   = 1'b1;
`endif
                        end
                    end
                    4:       e.rdata = 32'(mq[c].size());
                    8:       e.rdata = 32'(m_pkts(c));
                    default: e.rdata = {29'b0, m_ovr[c], mq[c].size() == DEPTH, mq[c].size() == 0};
                endcase
            end
        end
        exp_q.push_back(e);
        // irq seen next cycle reflects this cycle's pending/mask state.
        m_irq_next = |(m_pend() & m_mask);
        if (wen && addr == 'h804) m_mask = wd[NUM_CH-1:0];
        if (do_pop) void'(mq[c].pop_front());
        if (do_clr) m_ovr[c] = 1'b0;
        if (pw) begin
            if (mq[pch].size() < DEPTH) mq[pch].push_back({pl, pd});
            else m_ovr[pch] = 1'b1;
        end
    endtask

    task automatic cyc(input bit pw, input int pch, input logic [31:0] pd, input bit pl,
                       input bit ren, input bit wen, input int addr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        n_rst     = 1'b1;
        rx_wen    = pw;
        rx_ch     = pch[CH_W-1:0];
        rx_wdata  = pd;
        rx_last   = pl;
        bus_ren   = ren;
        bus_wen   = wen;
        bus_addr  = addr[AW-1:0];
        bus_wdata = wd;
        model_step(pw, pch, pd, pl, ren, wen, addr, wd);
    endtask

    task automatic push(input int ch, input logic [31:0] d, input bit l);
        cyc(1'b1, ch, d, l, 1'b0, 1'b0, 0, 32'h0);
    endtask
    task automatic rd(input int a);
        cyc(1'b0, 0, 32'h0, 1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask
    task automatic wr(input int a, input logic [31:0] d);
        cyc(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1, a, d);
    endtask
    task automatic idle();
        cyc(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_rst   = 1'b0;
        rx_wen  = 1'b0;
        bus_ren = 1'b0;
        bus_wen = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
    endtask

    // Monitor: one expected response per post-reset cycle.
    always @(negedge clk) begin
        if (n_rst) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: DUT cycle with no expected entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", e.addr, bus_rdata, e.rdata);
                chk("error", e.addr, 32'(bus_error), 32'(e.err));
                chk("stall", e.addr, 32'(bus_request_stall), 32'(e.stall));
                chk("irq",   e.addr, 32'(irq), 32'(e.irq));
                if (e.strobe)
                    $display("[TB] t=%0t addr=%03h ren=%0b wen=%0b rdata=%h err=%0b stall=%0b irq=%0b",
                             $time, bus_addr, bus_ren, bus_wen, bus_rdata, bus_error, bus_request_stall, irq);
            end
        end
    end

    initial begin
        do_reset();
        rd('h004); rd('h00C); rd('h804);

        push(1, 32'hA0, 1'b0); push(1, 32'hA1, 1'b0); push(1, 32'hA2, 1'b1);
        rd('h044); rd('h048); rd('h800);
        wr('h804, 32'h2); idle(); idle();
        rd('h040); rd('h040); rd('h040);
        idle(); idle();

        for (int i = 0; i < DEPTH; i++) push(0, 32'h100 + i, (i % 3) == 2);
        push(0, 32'hDEAD, 1'b1);
        rd('h00C); rd('h008);
        wr('h00C, 32'h4);
        rd('h00C);

        // Full queue: push and pop in the same cycle.
        cyc(1'b1, 0, 32'h55, 1'b1, 1'b1, 1'b0, 'h000, 32'h0);
        rd('h004); rd('h00C); rd('h008);
        for (int i = 0; i < DEPTH; i++) rd('h000);
        rd('h00C);

        // Wrap-around on ch2 with interleaved bursts.
        for (int n = 0; n < 3 * DEPTH; ) begin
            int b;
            b = $urandom_range(1, DEPTH);
            for (int i = 0; i < b; i++) push(2, $urandom, $urandom_range(0, 1) == 1);
            rd('h084); rd('h088);
            for (int i = 0; i < b; i++) rd('h080);
            n += b;
        end

        rd('h080); rd('h080); rd('h080);
        cyc(1'b1, 2, 32'h77, 1'b1, 1'b1, 1'b0, 'h080, 32'h0);
        rd('h080);
        rd('h0C0); wr('h000, 32'h1); wr('h004, 32'h1); rd('h010); rd('h802); wr('h800, 32'h7);

        // Randomised traffic: push-heavy first half, pop-heavy second half.
        for (int k = 0; k < 3000; k++) begin
            bit pw, ren, wen;
            int pch, op, addr, ch;
            logic [31:0] wd;
            pw   = $urandom_range(0, 99) < ((k < 1500) ? 60 : 25);
            pch  = $urandom_range(0, NUM_CH - 1);
            op   = $urandom_range(0, 99);
            ch   = $urandom_range(0, NUM_CH);
            ren  = 1'b0;
            wen  = 1'b0;
            addr = 0;
            wd   = $urandom;
            if (op < 45)      begin ren = 1'b1; addr = ch * 64; end
            else if (op < 55) begin ren = 1'b1; addr = ch * 64 + 4; end
            else if (op < 62) begin ren = 1'b1; addr = ch * 64 + 8; end
            else if (op < 70) begin ren = 1'b1; addr = ch * 64 + 12; end
            else if (op < 75) begin wen = 1'b1; addr = ch * 64 + 12; end
            else if (op < 80) begin ren = 1'b1; addr = 'h800; end
            else if (op < 85) begin ren = 1'b1; addr = 'h804; end
            else if (op < 90) begin wen = 1'b1; addr = 'h804; end
            else if (op < 95) begin
                addr = $urandom_range(0, 4095);
                if ($urandom_range(0, 1) == 1) ren = 1'b1; else wen = 1'b1;
            end
            cyc(pw, pch, $urandom, $urandom_range(0, 3) == 0, ren, wen, addr, wd);
        end

        idle();
        @(negedge clk);
        #1;
        chk("drain", 0, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
